// File: rtl/sel_pkg.sv
// Shared types, mode constants and one-hot helper for the scanning path selector.
package sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest index the one-hot helper supports; callers cast down to their width.
  localparam int unsigned ONEHOT_MAX_SEL_W = 8;
  localparam int unsigned ONEHOT_MAX_W     = 2 ** ONEHOT_MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Index to one-hot vector at the maximum supported width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_MAX_SEL_W-1:0] idx);
    logic [ONEHOT_MAX_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sel_onehot_dec.sv
// Purely combinational index to one-hot decoder.
module sel_onehot_dec
  import sel_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]      idx_i,
  output logic [2**SEL_W-1:0]   onehot_c_o
);

  localparam int unsigned PATH_W = 2 ** SEL_W;

  // Decode at full helper width, then keep only the live paths.
  assign onehot_c_o = PATH_W'(onehot(ONEHOT_MAX_SEL_W'(idx_i)));

endmodule

// File: rtl/sel_scan_decoder.sv
// Registered one-hot path selector with direct select and timed auto-scan.
module sel_scan_decoder
  import sel_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     select,
  input  logic [SEL_W-1:0]     last_sel,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**SEL_W-1:0]  path,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 valid,
  output logic                 wrap
);

  localparam int unsigned PATH_W = 2 ** SEL_W;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [PATH_W-1:0]    path_q, path_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;
  logic [PATH_W-1:0]    dec_path;

  // Single decoder sits on the next-index mux so path tracks cur_sel on the same edge.
  sel_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .idx_i      (cur_sel_d),
    .onehot_c_o (dec_path)
  );

  // Next-state selection and per-state index / dwell counter update.
  always_comb begin
    state_d   = IDLE;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;

    if (en) begin
      state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end

    case (state_d)
      DIRECT: begin
        cur_sel_d = select;
        cnt_d     = '0;
        valid_d   = 1'b1;
      end
      SCAN: begin
        valid_d = 1'b1;
        if (state_q != SCAN) begin
          // Entry: restart dwell on whatever index is current.
          cnt_d = '0;
        end else if (cnt_q == dwell) begin
          cnt_d = '0;
          if (cur_sel_q >= last_sel) begin
            cur_sel_d = '0;
            wrap_d    = 1'b1;
          end else begin
            cur_sel_d = cur_sel_q + SEL_W'(1);
          end
        end else begin
          // Free-running increment; a lowered dwell is caught after rollover.
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Path is blank whenever the output is not live.
  assign path_d = valid_d ? dec_path : '0;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      cnt_q     <= '0;
      path_q    <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
      path_q    <= path_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign path    = path_q;
  assign cur_sel = cur_sel_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_sel_scan_decoder.sv
// Directed self-checking bench for sel_scan_decoder (SEL_W=2, DWELL_W=8).
module tb_sel_scan_decoder;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] select;
  logic [1:0] last_sel;
  logic [7:0] dwell;
  logic [3:0] path;
  logic [1:0] cur_sel;
  logic       valid;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  sel_scan_decoder #(
    .SEL_W   (2),
    .DWELL_W (8)
  ) dut (
    .clk1     (clk1),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .select   (select),
    .last_sel (last_sel),
    .dwell    (dwell),
    .path     (path),
    .cur_sel  (cur_sel),
    .valid    (valid),
    .wrap     (wrap)
  );

  always #5 clk1 = ~clk1;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output check: expected path is one-hot of expected index when live.
  task automatic chk_out(input string tag, input logic [1:0] exp_cs, input logic exp_valid,
                         input logic exp_wrap);
    logic [3:0] exp_path;
    exp_path = exp_valid ? (4'b0001 << exp_cs) : 4'b0000;
    chk({tag, ".path"},    32'(path),    32'(exp_path));
    chk({tag, ".cur_sel"}, 32'(cur_sel), 32'(exp_cs));
    chk({tag, ".valid"},   32'(valid),   32'(exp_valid));
    chk({tag, ".wrap"},    32'(wrap),    32'(exp_wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1;
    select = 2'd0; last_sel = 2'd3; dwell = 8'd2;

    // Reset held three cycles with scan requested.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("reset", 2'd0, 1'b0, 1'b0);
    end

    // Full scan, dwell=2, last_sel=3: each index for 3 edges, wrap at edge 13.
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk_out($sformatf("scan_full_e%0d", k), 2'(((k - 1) / 3) % 4), 1'b1, k == 13);
    end
    // Continue to the first edge that shows index 2 again (edge 19).
    for (int k = 14; k <= 19; k++) begin
      step();
      chk_out($sformatf("scan_cont_e%0d", k), 2'(((k - 1) / 3) % 4), 1'b1, 1'b0);
    end

    // Reset mid-scan at cur_sel=2.
    rst = 1'b1;
    step();
    chk_out("reset_mid", 2'd0, 1'b0, 1'b0);

    // Limited scan, dwell=0, last_sel=1: entry at 0, then alternate.
    rst = 1'b0; dwell = 8'd0; last_sel = 2'd1;
    step(); chk_out("lim_e1", 2'd0, 1'b1, 1'b0);
    step(); chk_out("lim_e2", 2'd1, 1'b1, 1'b0);
    step(); chk_out("lim_e3", 2'd0, 1'b1, 1'b1);
    step(); chk_out("lim_e4", 2'd1, 1'b1, 1'b0);

    // Lower limit below current index: immediate wrap, then pinned to 0.
    last_sel = 2'd0;
    step(); chk_out("pin_e1", 2'd0, 1'b1, 1'b1);
    step(); chk_out("pin_e2", 2'd0, 1'b1, 1'b1);
    step(); chk_out("pin_e3", 2'd0, 1'b1, 1'b1);

    // Walk up to index 2 with dwell=2 (counter is 0 at index 0).
    last_sel = 2'd3; dwell = 8'd2;
    step(); chk_out("walk_e1", 2'd0, 1'b1, 1'b0);
    step(); chk_out("walk_e2", 2'd0, 1'b1, 1'b0);
    step(); chk_out("walk_e3", 2'd1, 1'b1, 1'b0);
    step(); step();
    step(); chk_out("walk_e6", 2'd2, 1'b1, 1'b0);

    // Enable gap: blank output, index held.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("gap_%0d", i), 2'd2, 1'b0, 1'b0);
    end

    // Re-enable: index 2 immediately, dwell restarts so it lasts 3 edges.
    en = 1'b1;
    step(); chk_out("reen_e1", 2'd2, 1'b1, 1'b0);
    step(); chk_out("reen_e2", 2'd2, 1'b1, 1'b0);
    step(); chk_out("reen_e3", 2'd2, 1'b1, 1'b0);
    step(); chk_out("reen_e4", 2'd3, 1'b1, 1'b0);

    // Switch to direct at cur_sel=3 with select=1.
    select = 2'd1; mode = 1'b0;
    step(); chk_out("to_direct", 2'd1, 1'b1, 1'b0);

    // Back to scan: resumes from index 1 for 3 edges.
    mode = 1'b1;
    step(); chk_out("resume_e1", 2'd1, 1'b1, 1'b0);
    step(); chk_out("resume_e2", 2'd1, 1'b1, 1'b0);
    step(); chk_out("resume_e3", 2'd1, 1'b1, 1'b0);
    step(); chk_out("resume_e4", 2'd2, 1'b1, 1'b0);

    // Direct sweep with one-cycle latency.
    mode = 1'b0;
    select = 2'd0; step(); chk_out("dir_0", 2'd0, 1'b1, 1'b0);
    select = 2'd1; step(); chk_out("dir_1", 2'd1, 1'b1, 1'b0);
    select = 2'd2; step(); chk_out("dir_2", 2'd2, 1'b1, 1'b0);
    select = 2'd3; step(); chk_out("dir_3", 2'd3, 1'b1, 1'b0);

    // Scan from index 3 at dwell=0: wraps to 0 on the second edge.
    mode = 1'b1; dwell = 8'd0;
    step(); chk_out("wrap3_e1", 2'd3, 1'b1, 1'b0);
    step(); chk_out("wrap3_e2", 2'd0, 1'b1, 1'b1);
    step(); chk_out("wrap3_e3", 2'd1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_scan_decoder.md
Name: sel_scan_decoder

Overview:
- Parametrised successor to the team's 2-to-4 path selector: SEL_W-bit index to one-hot 2**SEL_W path output.
- Path output is registered. Adds enable, an auto-scan mode that rotates through paths with a programmable dwell time, a scan upper limit, and a wrap pulse.
- Sits between control logic and path muxes/LED banks; in scan mode it drives time-multiplexed outputs without CPU intervention.

Parameters:
- SEL_W, 2, select index width; path width is 2**SEL_W.
- DWELL_W, 8, dwell counter width.

Ports:
- clk1  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- select  in  SEL_W  path index used in DIRECT mode.
- last_sel  in  SEL_W  highest index visited in SCAN mode.
- dwell  in  DWELL_W  cycles per path in SCAN mode, minus 1.
- path  out  2**SEL_W  registered one-hot path enable.
- cur_sel  out  SEL_W  index currently driving path.
- valid  out  1  high when path holds a live one-hot value.
- wrap  out  1  one-cycle pulse when scan returns to index 0.

Behaviour:
- Interface: one clock, clk1; reset rst is synchronous, active-high.
- Reset: path=0, cur_sel=0, valid=0, wrap=0, dwell counter=0, FSM=IDLE. rst overrides every other input on the same edge, including mid-scan.
- FSM states: IDLE, DIRECT, SCAN. The state is re-evaluated every cycle.
  - en=0 -> IDLE.
  - en=1 and mode=0 -> DIRECT.
  - en=1 and mode=1 -> SCAN.
- IDLE:
  - path=0, valid=0, wrap=0.
  - cur_sel and dwell counter hold their values.
- DIRECT:
  - Each cycle, cur_sel <= select and path <= onehot(select); valid=1.
  - Latency is 1 cycle from select to path.
  - The dwell counter is held at 0.
- SCAN entry (from IDLE or DIRECT):
  - The dwell counter clears to 0.
  - Scanning starts at the current cur_sel; path <= onehot(cur_sel) and valid=1 on the entry edge.
- SCAN advance:
  - The counter increments each cycle.
  - When counter == dwell, the counter resets to 0 and cur_sel advances.
  - Advance rule: if cur_sel >= last_sel then cur_sel <= 0 and wrap=1 for that one cycle; otherwise cur_sel <= cur_sel + 1.
  - path follows the new cur_sel on the same edge, so there is no gap cycle.
  - dwell=0 advances every cycle.
- Each index is shown for dwell+1 cycles, so one full scan period is (last_sel+1)*(dwell+1) cycles.
- last_sel = 2**SEL_W-1 scans all paths. last_sel=0 pins the scan to path 0 and pulses wrap every dwell+1 cycles.
- Changing last_sel below cur_sel mid-scan: the next advance goes to 0 with wrap=1. Indices above last_sel are never revisited.
- Changing dwell mid-scan: takes effect on the next compare. If the counter is already > new dwell, the counter runs to its all-ones value, rolls over to 0, and continues counting up. It advances when it next equals dwell. No extra wrap is generated.
- SCAN -> DIRECT switch: on the next edge path <= onehot(select) and wrap=0.
- Invariant: path is either all-zero (only when valid=0) or exactly one-hot matching cur_sel.
- Arithmetic:
  - cur_sel wraps modulo 2**SEL_W naturally; the explicit last_sel compare takes precedence.
  - The dwell counter is DWELL_W bits, unsigned.

Decomposition:
- Package sel_pkg:
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - FSM state encoding IDLE/DIRECT/SCAN as a 2-bit typedef.
  - Function onehot(idx) returning the 2**SEL_W one-hot vector.
- Sub-module sel_onehot_dec: parametrised by SEL_W, purely combinational index to one-hot. Instantiated once; its output is registered in the top.

Test Plan (SEL_W=2, DWELL_W=8 unless stated):
- Reset: hold rst 3 cycles with en=1, mode=1 -> path=4'b0000, valid=0, wrap=0, cur_sel=0. Assert rst mid-scan at cur_sel=2 -> the same values on the next edge.
- DIRECT sweep: en=1, mode=0, select=0,1,2,3 on consecutive cycles -> path=0001,0010,0100,1000 each one cycle later; valid=1 throughout.
- Full SCAN: mode=1, last_sel=3, dwell=2 from cur_sel=0 -> each path held 3 cycles, order 0,1,2,3,0; wrap high exactly 1 cycle at the 3->0 transition; period 12 cycles.
- Limited SCAN with dwell=0: last_sel=1 -> path alternates 0001/0010 every cycle; wrap every 2nd cycle. Then lower last_sel to 0 while cur_sel=1 -> next edge cur_sel=0, wrap=1, and the scan pins to path 0.
- Enable gating: drop en for 5 cycles mid-scan at cur_sel=2 -> path=0 and valid=0 during the gap. Re-raise en -> path=0100 immediately and the dwell count restarts from 0.
- Mode switch: SCAN at cur_sel=3 with select=1, switch mode to 0 -> next edge path=0010, wrap=0. Switch back to 1 -> scan resumes from cur_sel=1.
